// File: rtl/can_err_ovld_frame_gen.sv
// CAN error/overload frame generator: flag, echo tracking, delimiter and intermission.
// Optional back-to-back overload limit enabled by defining CAN_OVLD_LIMIT_EN.
module can_err_ovld_frame_gen #(
    parameter int FLAG_LEN   = 6,
    parameter int DELIM_LEN  = 8,
    parameter int INTERM_LEN = 3,
    parameter int ECHO_MAX   = 12,
    parameter int CNT_W      = 4,
    parameter int MAX_OVLD   = 2
) (
    input  logic samplePoint,
    input  logic reset,
    input  logic canRX,
    input  logic frameReady,
    input  logic isError,
    input  logic errorPassive,
    input  logic overloadReq,
    output logic canTX,
    output logic isStart,
    output logic endError,
    output logic endOverload,
    output logic busy
);

    if ((2 ** CNT_W) <= ECHO_MAX) begin : g_chk_echo
        $error("CNT_W too narrow for ECHO_MAX");
    end
    if ((2 ** CNT_W) <= DELIM_LEN) begin : g_chk_delim
        $error("CNT_W too narrow for DELIM_LEN");
    end
    if ((2 ** CNT_W) <= FLAG_LEN) begin : g_chk_flag
        $error("CNT_W too narrow for FLAG_LEN");
    end
    if ((2 ** CNT_W) <= INTERM_LEN) begin : g_chk_interm
        $error("CNT_W too narrow for INTERM_LEN");
    end
    if (MAX_OVLD < 1) begin : g_chk_ovld
        $error("MAX_OVLD must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_ECHO,
        S_DELIM,
        S_INTERM
    } state_t;

    localparam logic KIND_ERR  = 1'b0;
    localparam logic KIND_OVLD = 1'b1;

    localparam logic [CNT_W-1:0] C_FLAG   = CNT_W'(FLAG_LEN);
    localparam logic [CNT_W-1:0] C_DELIM  = CNT_W'(DELIM_LEN);
    localparam logic [CNT_W-1:0] C_INTERM = CNT_W'(INTERM_LEN);
    localparam logic [CNT_W-1:0] C_ECHO   = CNT_W'(ECHO_MAX);

    state_t           r_state, w_state_next;
    logic             r_kind, w_kind_next;
    logic             r_passive, w_passive_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc, w_run;
    logic             r_last_rx, w_last_rx_next;
    logic             r_tx, r_is_start, r_end_err, r_end_ovld, r_busy;
    logic             w_is_start_next, w_end_err_next, w_end_ovld_next;
    logic             w_err_start, w_ovld_start, w_ovld_ok;
    logic             w_flag_active;

    assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_flag_active = (r_kind == KIND_OVLD) || !r_passive;

`ifdef CAN_OVLD_LIMIT_EN
    localparam int OVLD_W = (MAX_OVLD < 2) ? 1 : $clog2(MAX_OVLD + 1);
    localparam logic [OVLD_W-1:0] C_MAX_OVLD = OVLD_W'(MAX_OVLD);

    logic [OVLD_W-1:0] r_ovld_cnt;

    assign w_ovld_ok = (r_ovld_cnt != C_MAX_OVLD);

    // Back-to-back overload run length; any error frame or return to IDLE ends the run.
    always_ff @(posedge samplePoint or posedge reset) begin
        if (reset) begin
            r_ovld_cnt <= '0;
        end else if (w_err_start || (w_state_next == S_IDLE)) begin
            r_ovld_cnt <= '0;
        end else if (w_ovld_start && (r_ovld_cnt != '1)) begin
            r_ovld_cnt <= r_ovld_cnt + 1'b1;
        end
    end
`else
    assign w_ovld_ok = 1'b1;
`endif

    always_ff @(posedge samplePoint or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_kind     <= KIND_ERR;
            r_passive  <= 1'b0;
            r_cnt      <= '0;
            r_last_rx  <= 1'b1;
            r_tx       <= 1'b1;
            r_is_start <= 1'b0;
            r_end_err  <= 1'b0;
            r_end_ovld <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_kind     <= w_kind_next;
            r_passive  <= w_passive_next;
            r_cnt      <= w_cnt_next;
            r_last_rx  <= w_last_rx_next;
            r_tx       <= !((w_state_next == S_FLAG) &&
                            ((w_kind_next == KIND_OVLD) || !w_passive_next));
            r_is_start <= w_is_start_next;
            r_end_err  <= w_end_err_next;
            r_end_ovld <= w_end_ovld_next;
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_kind_next     = r_kind;
        w_passive_next  = r_passive;
        w_cnt_next      = r_cnt;
        w_last_rx_next  = r_last_rx;
        w_is_start_next = 1'b0;
        w_end_err_next  = 1'b0;
        w_end_ovld_next = 1'b0;
        w_err_start     = 1'b0;
        w_ovld_start    = 1'b0;
        w_run           = '0;

        if (isError && (r_state != S_FLAG)) begin
            w_err_start = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frameReady && overloadReq && w_ovld_ok) begin
                        w_ovld_start = 1'b1;
                    end
                end
                S_FLAG: begin
                    if (w_flag_active) begin
                        if (w_cnt_inc == C_FLAG) begin
                            w_state_next = S_ECHO;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        // Passive flag ends after FLAG_LEN consecutive equal bus bits.
                        w_run          = ((r_cnt == '0) || (canRX == r_last_rx)) ?
                                         w_cnt_inc : CNT_W'(1);
                        w_last_rx_next = canRX;
                        if (w_run == C_FLAG) begin
                            w_state_next = S_ECHO;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_run;
                        end
                    end
                end
                S_ECHO: begin
                    if (canRX) begin
                        w_state_next = S_DELIM;
                        w_cnt_next   = CNT_W'(1);
                    end else if (w_cnt_inc == C_ECHO) begin
                        w_err_start = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                S_DELIM: begin
                    if (canRX) begin
                        if (w_cnt_inc == C_DELIM) begin
                            w_state_next    = S_INTERM;
                            w_cnt_next      = '0;
                            w_end_err_next  = (r_kind == KIND_ERR);
                            w_end_ovld_next = (r_kind == KIND_OVLD);
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else if ((r_kind == KIND_OVLD) && (w_cnt_inc == C_DELIM)) begin
                        // Dominant on the last overload delimiter bit is an overload condition.
                        if (w_ovld_ok) begin
                            w_ovld_start = 1'b1;
                        end else begin
                            w_state_next    = S_INTERM;
                            w_cnt_next      = '0;
                            w_end_ovld_next = 1'b1;
                        end
                    end else begin
                        w_err_start = 1'b1;
                    end
                end
                S_INTERM: begin
                    if (!canRX && (w_cnt_inc < C_INTERM) && w_ovld_ok) begin
                        w_ovld_start = 1'b1;
                    end else if (w_cnt_inc == C_INTERM) begin
                        w_state_next    = S_IDLE;
                        w_cnt_next      = '0;
                        w_is_start_next = !canRX;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end

        if (w_err_start) begin
            w_state_next   = S_FLAG;
            w_kind_next    = KIND_ERR;
            w_passive_next = errorPassive;
            w_cnt_next     = '0;
        end else if (w_ovld_start) begin
            w_state_next   = S_FLAG;
            w_kind_next    = KIND_OVLD;
            w_passive_next = errorPassive;
            w_cnt_next     = '0;
        end
    end

    assign canTX       = r_tx;
    assign isStart     = r_is_start;
    assign endError    = r_end_err;
    assign endOverload = r_end_ovld;
    assign busy        = r_busy;

endmodule

// File: tb/tb_can_err_ovld_frame_gen.sv
// Directed table-driven bench for can_err_ovld_frame_gen; outputs packed as {canTX,busy,endError,endOverload,isStart}.
module tb_can_err_ovld_frame_gen;

    logic samplePoint = 1'b0;
    logic reset, canRX, frameReady, isError, errorPassive, overloadReq;
    logic canTX, isStart, endError, endOverload, busy;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [4:0] O_IDLE = 5'b10000;
    localparam logic [4:0] O_FLG  = 5'b01000;
    localparam logic [4:0] O_RCS  = 5'b11000;
    localparam logic [4:0] O_EE   = 5'b11100;
    localparam logic [4:0] O_EO   = 5'b11010;
    localparam logic [4:0] O_SOF  = 5'b10001;

    can_err_ovld_frame_gen dut (
        .samplePoint (samplePoint),
        .reset       (reset),
        .canRX       (canRX),
        .frameReady  (frameReady),
        .isError     (isError),
        .errorPassive(errorPassive),
        .overloadReq (overloadReq),
        .canTX       (canTX),
        .isStart     (isStart),
        .endError    (endError),
        .endOverload (endOverload),
        .busy        (busy)
    );

    always #5 samplePoint = ~samplePoint;

    typedef struct {
        string      name;
        logic       ie;
        logic       pas;
        logic       rx;
        logic       fr;
        logic       ovr;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input int n, input logic ie, input logic pas,
                       input logic rx, input logic fr, input logic ovr, input logic [4:0] e);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.name = $sformatf("%s[%0d]", nm, i);
            v.ie = ie; v.pas = pas; v.rx = rx; v.fr = fr; v.ovr = ovr; v.exp = e;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {canTX, busy, endError, endOverload, isStart};
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: tx/busy/eE/eO/sof got %b expected %b", nm, act, exp);
        end else begin
            $display("ok   %s: tx/busy/eE/eO/sof=%b", nm, act);
        end
    endtask

    task automatic drive(input logic ie, input logic pas, input logic rx,
                         input logic fr, input logic ovr);
        isError = ie; errorPassive = pas; canRX = rx; frameReady = fr; overloadReq = ovr;
    endtask

    task automatic step;
        @(posedge samplePoint);
        #1;
    endtask

    // One overload frame from the edge that starts it up to the endOverload pulse.
    task automatic ovld_body(input string nm);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0); step(); check({nm, "_flag"}, O_FLG);
        end
        drive(0, 0, 0, 0, 0); step(); check({nm, "_echo"}, O_RCS);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 0, 0); step(); check({nm, "_delim"}, O_RCS);
        end
        drive(0, 0, 1, 0, 0); step(); check({nm, "_endovl"}, O_EO);
    endtask

    task automatic pulse_reset;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 1, 0, 0);
        #2;
        check("reset_state", O_IDLE);
        #4 reset = 1'b0;

        // Active error frame with clean recessive intermission
        add("t2_trig",   1, 1, 0, 1, 0, 0, O_FLG);
        add("t2_flag",   5, 0, 0, 0, 0, 0, O_FLG);
        add("t2_echo",   1, 0, 0, 0, 0, 0, O_RCS);
        add("t2_delim",  7, 0, 0, 1, 0, 0, O_RCS);
        add("t2_enderr", 1, 0, 0, 1, 0, 0, O_EE);
        add("t2_interm", 2, 0, 0, 1, 0, 0, O_RCS);
        add("t2_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
        // Passive error: errorPassive dropped after entry must not matter
        add("t3_trig",   1, 1, 1, 1, 0, 0, O_RCS);
        add("t3_b1",     1, 0, 0, 1, 0, 0, O_RCS);
        add("t3_b2",     1, 0, 0, 0, 0, 0, O_RCS);
        add("t3_run",    6, 0, 0, 1, 0, 0, O_RCS);
        add("t3_delim",  7, 0, 0, 1, 0, 0, O_RCS);
        add("t3_enderr", 1, 0, 0, 1, 0, 0, O_EE);
        add("t3_interm", 2, 0, 0, 1, 0, 0, O_RCS);
        add("t3_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
        // Overload frame ending in SOF at the last intermission bit
        add("t4_trig",   1, 0, 0, 1, 1, 1, O_FLG);
        add("t4_flag",   5, 0, 0, 0, 0, 0, O_FLG);
        add("t4_echo",   1, 0, 0, 0, 0, 0, O_RCS);
        add("t4_delim",  7, 0, 0, 1, 0, 0, O_RCS);
        add("t4_endovl", 1, 0, 0, 1, 0, 0, O_EO);
        add("t4_interm", 2, 0, 0, 1, 0, 0, O_RCS);
        add("t4_sof",    1, 0, 0, 0, 0, 0, O_SOF);
        add("t4_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
        // Stuck-dominant bus during echo restarts an error flag
        add("t5_trig",   1, 1, 0, 1, 0, 0, O_FLG);
        add("t5_flag",   5, 0, 0, 0, 0, 0, O_FLG);
        add("t5_echo",   1, 0, 0, 0, 0, 0, O_RCS);
        add("t5_stuck", 11, 0, 0, 0, 0, 0, O_RCS);
        add("t5_reflag", 1, 0, 0, 0, 0, 0, O_FLG);
        add("t5_flag2",  5, 0, 0, 0, 0, 0, O_FLG);
        add("t5_echo2",  1, 0, 0, 0, 0, 0, O_RCS);
        add("t5_delim",  7, 0, 0, 1, 0, 0, O_RCS);
        add("t5_enderr", 1, 0, 0, 1, 0, 0, O_EE);
        add("t5_interm", 2, 0, 0, 1, 0, 0, O_RCS);
        add("t5_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
        // Dominant on the last overload delimiter bit starts a new overload flag
        add("t7_trig",   1, 0, 0, 1, 1, 1, O_FLG);
        add("t7_flag",   5, 0, 0, 0, 0, 0, O_FLG);
        add("t7_echo",   1, 0, 0, 0, 0, 0, O_RCS);
        add("t7_delim",  7, 0, 0, 1, 0, 0, O_RCS);
        add("t7_lastdom",1, 0, 0, 0, 0, 0, O_FLG);
        add("t7_flag2",  5, 0, 0, 0, 0, 0, O_FLG);
        add("t7_echo2",  1, 0, 0, 0, 0, 0, O_RCS);
        add("t7_delim2", 7, 0, 0, 1, 0, 0, O_RCS);
        add("t7_endovl", 1, 0, 0, 1, 0, 0, O_EO);
        add("t7_interm", 2, 0, 0, 1, 0, 0, O_RCS);
        add("t7_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
        // Dominant bit inside an error delimiter starts a fresh error flag
        add("t8_trig",   1, 1, 0, 1, 0, 0, O_FLG);
        add("t8_flag",   5, 0, 0, 0, 0, 0, O_FLG);
        add("t8_echo",   1, 0, 0, 0, 0, 0, O_RCS);
        add("t8_delim",  3, 0, 0, 1, 0, 0, O_RCS);
        add("t8_dom",    1, 0, 0, 0, 0, 0, O_FLG);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ie, vecs[i].pas, vecs[i].rx, vecs[i].fr, vecs[i].ovr);
            step();
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset while the error flag is being driven
        drive(0, 0, 0, 0, 0);
        step();
        check("t1_pre_reset", O_FLG);
        #2 reset = 1'b1;
        #1 check("t1_async_reset", O_IDLE);
        #2 reset = 1'b0;
        drive(0, 0, 1, 0, 0);
        step();
        check("t1_idle_after", O_IDLE);

        // Back-to-back overload frames started from intermission bit 1
        drive(0, 0, 1, 1, 1); step(); check("t6_trig1", O_FLG);
        ovld_body("t6_f1");
        drive(0, 0, 0, 0, 0); step(); check("t6_trig2", O_FLG);
        ovld_body("t6_f2");
        drive(0, 0, 0, 0, 0); step();
`ifdef CAN_OVLD_LIMIT_EN
        check("t6_third_ignored", O_RCS);
        drive(0, 0, 1, 0, 0); step(); check("t6_interm2", O_RCS);
        drive(0, 0, 1, 0, 0); step(); check("t6_idle", O_IDLE);
`else
        check("t6_third_flag", O_FLG);
        pulse_reset();
        drive(0, 0, 1, 0, 0); step(); check("t6_idle", O_IDLE);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
